// File: rtl/demux_wb.sv
// demux_wb: routes accepted write-back words into one-entry B/R holding slots with valid/ready outputs
module demux_wb #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     D,
  input  logic                 IN_VALID,
  input  logic                 DEMUX_SEL,
  output logic                 IN_READY,
  output logic [WIDTH-1:0]     B_OUT,
  output logic                 B_VALID,
  input  logic                 B_READY,
  output logic [WIDTH-1:0]     R_OUT,
  output logic                 R_VALID,
  input  logic                 R_READY,
  output logic [CNT_WIDTH-1:0] STALL_CNT
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_e;
  slot_e b_q, r_q, b_d, r_d;
  logic [WIDTH-1:0] b_out_q, r_out_q, b_out_d, r_out_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic b_drain, r_drain, accept, b_load, r_load, stall;
  assign b_drain  = (b_q == FULL) & B_READY;
  assign r_drain  = (r_q == FULL) & R_READY;
  // Ready looks through the selected slot's drain so a full slot can take a word every cycle
  assign IN_READY = DEMUX_SEL ? ((b_q == EMPTY) | b_drain) : ((r_q == EMPTY) | r_drain);
  assign accept   = IN_VALID & IN_READY;
  assign b_load   = accept & DEMUX_SEL;
  assign r_load   = accept & ~DEMUX_SEL;
  assign stall    = IN_VALID & ~IN_READY;
  always_comb begin
    b_d     = b_load ? FULL : (b_drain ? EMPTY : b_q);
    r_d     = r_load ? FULL : (r_drain ? EMPTY : r_q);
    b_out_d = b_load ? D : b_out_q;
    r_out_d = r_load ? D : r_out_q;
    cnt_d   = (stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      b_q     <= EMPTY;
      r_q     <= EMPTY;
      b_out_q <= '0;
      r_out_q <= '0;
      cnt_q   <= '0;
    end else begin
      b_q     <= b_d;
      r_q     <= r_d;
      b_out_q <= b_out_d;
      r_out_q <= r_out_d;
      cnt_q   <= cnt_d;
    end
  end
  assign B_VALID   = (b_q == FULL);
  assign R_VALID   = (r_q == FULL);
  assign B_OUT     = b_out_q;
  assign R_OUT     = r_out_q;
  assign STALL_CNT = cnt_q;
endmodule

// File: tb/tb_demux_wb.sv
// tb_demux_wb: directed and random checks of demux_wb against a slot-occupancy reference model
module tb_demux_wb;
  logic CLK = 0, RST = 0, IN_VALID = 0, DEMUX_SEL = 0, B_READY = 0, R_READY = 0;
  logic [3:0] D = 0;
  logic IN_READY, B_VALID, R_VALID, IN_READY2, B_VALID2, R_VALID2;
  logic [3:0] B_OUT, R_OUT, B_OUT2, R_OUT2;
  logic [7:0] STALL_CNT;
  logic [1:0] STALL_CNT2;
  int checks = 0, errors = 0;
  bit known = 0;
  bit mb_full, mr_full;
  int mb, mr, ms8, ms2, delivered;
  always #5 CLK = ~CLK;
  demux_wb #(.WIDTH(4), .CNT_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .D(D), .IN_VALID(IN_VALID), .DEMUX_SEL(DEMUX_SEL), .IN_READY(IN_READY),
    .B_OUT(B_OUT), .B_VALID(B_VALID), .B_READY(B_READY), .R_OUT(R_OUT), .R_VALID(R_VALID),
    .R_READY(R_READY), .STALL_CNT(STALL_CNT));
  demux_wb #(.WIDTH(4), .CNT_WIDTH(2)) dut2 (
    .CLK(CLK), .RST(RST), .D(D), .IN_VALID(IN_VALID), .DEMUX_SEL(DEMUX_SEL), .IN_READY(IN_READY2),
    .B_OUT(B_OUT2), .B_VALID(B_VALID2), .B_READY(B_READY), .R_OUT(R_OUT2), .R_VALID(R_VALID2),
    .R_READY(R_READY), .STALL_CNT(STALL_CNT2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cycle();
    bit rdy, acc, nb_full, nr_full;
    int nb, nr;
    @(negedge CLK);
    rdy = DEMUX_SEL ? (!mb_full || B_READY) : (!mr_full || R_READY);
    if (known) begin
      chk("in_ready", IN_READY, rdy);
      chk("b_valid", B_VALID, mb_full);
      chk("r_valid", R_VALID, mr_full);
      chk("b_out", B_OUT, mb);
      chk("r_out", R_OUT, mr);
      chk("stall8", STALL_CNT, ms8);
      chk("stall2", STALL_CNT2, ms2);
    end
    acc = IN_VALID && rdy;
    nb_full = mb_full; nr_full = mr_full; nb = mb; nr = mr;
    if (mb_full && B_READY) begin nb_full = 0; delivered++; end
    if (mr_full && R_READY) begin nr_full = 0; delivered++; end
    if (acc && DEMUX_SEL) begin nb_full = 1; nb = D; end
    if (acc && !DEMUX_SEL) begin nr_full = 1; nr = D; end
    @(posedge CLK);
    #1;
    if (RST) begin
      known = 1; mb_full = 0; mr_full = 0; mb = 0; mr = 0; ms8 = 0; ms2 = 0;
    end else begin
      if (IN_VALID && !rdy) begin
        ms8 = (ms8 < 255) ? ms8 + 1 : 255;
        ms2 = (ms2 < 3) ? ms2 + 1 : 3;
      end
      mb_full = nb_full; mr_full = nr_full; mb = nb; mr = nr;
    end
  endtask
  task automatic drive(input bit v, input bit s, input logic [3:0] d, input bit br, input bit rr);
    IN_VALID = v; DEMUX_SEL = s; D = d; B_READY = br; R_READY = rr;
  endtask
  initial begin
    int dsave;
    RST = 1; cycle(); RST = 0;
    chk("rst_b_valid", B_VALID, 0); chk("rst_r_valid", R_VALID, 0);
    chk("rst_b_out", B_OUT, 0); chk("rst_r_out", R_OUT, 0);
    chk("rst_ready", IN_READY, 1); chk("rst_stall", STALL_CNT, 0);
    cycle();
    drive(1, 1, 4'hA, 0, 0); cycle();
    drive(0, 1, 4'h0, 0, 0);
    chk("b_load_valid", B_VALID, 1); chk("b_load_out", B_OUT, 4'hA); chk("b_load_r_valid", R_VALID, 0);
    cycle();
    B_READY = 1; cycle(); B_READY = 0;
    chk("b_drain_valid", B_VALID, 0); chk("b_drain_out_hold", B_OUT, 4'hA);
    drive(1, 0, 4'h3, 0, 0); cycle();
    D = 4'h5; cycle(); cycle(); cycle();
    chk("bp_ready", IN_READY, 0); chk("bp_stall", STALL_CNT, 3);
    R_READY = 1; #1;
    chk("bp_release_ready", IN_READY, 1);
    cycle();
    IN_VALID = 0;
    chk("bp_r_out", R_OUT, 4'h5); chk("bp_r_valid", R_VALID, 1);
    drive(1, 1, 4'h9, 0, 1); cycle();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 4'(i), 0, 1); cycle();
      chk("stream_r_out", R_OUT, i); chk("stream_r_valid", R_VALID, 1);
      chk("stream_b_out", B_OUT, 4'h9); chk("stream_b_valid", B_VALID, 1);
    end
    chk("stream_no_stall", STALL_CNT, 3);
    drive(1, 1, 4'hC, 1, 1); cycle();
    drive(1, 0, 4'h7, 0, 1); cycle();
    drive(0, 0, 4'h0, 0, 0);
    chk("pre_rst_b", B_OUT, 4'hC); chk("pre_rst_r", R_OUT, 4'h7);
    dsave = delivered;
    RST = 1; cycle(); RST = 0;
    chk("mid_rst_b_valid", B_VALID, 0); chk("mid_rst_r_valid", R_VALID, 0);
    chk("mid_rst_b_out", B_OUT, 0); chk("mid_rst_r_out", R_OUT, 0);
    drive(0, 0, 4'h0, 1, 1); cycle();
    chk("mid_rst_not_delivered", delivered, dsave);
    drive(1, 0, 4'h6, 0, 0); cycle();
    for (int i = 0; i < 6; i++) cycle();
    chk("sat2", STALL_CNT2, 3); chk("sat8", STALL_CNT, 6);
    cycle();
    chk("sat2_hold", STALL_CNT2, 3);
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      RST = ($urandom_range(0, 79) == 0);
      cycle();
    end
    RST = 0; IN_VALID = 0; cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux_wb.md
# demux_wb

Write-back demultiplexer for the simple CPU datapath, the reverse of the B/R source-select multiplexer. It accepts one WIDTH-bit result word per handshake and routes it to either the B destination or the R destination. Each destination has its own one-entry holding register and its own valid/ready output handshake. A saturating counter records input stall cycles for debug visibility.

## Interface
Parameters:
- WIDTH, 4, data width of the input and of both destination words
- CNT_WIDTH, 8, width of the stall counter

Ports:
- CLK  input  1  single clock; all state updates on rising edge
- RST  input  1  reset, synchronous, active-high
- D  input  WIDTH  result word to route
- IN_VALID  input  1  D and DEMUX_SEL are valid this cycle
- DEMUX_SEL  input  1  routing select: 1 routes to B, 0 routes to R
- IN_READY  output  1  block can accept the current word
- B_OUT  output  WIDTH  B destination word
- B_VALID  output  1  B_OUT holds an undelivered word
- B_READY  input  1  B destination consumes B_OUT this cycle
- R_OUT  output  WIDTH  R destination word
- R_VALID  output  1  R_OUT holds an undelivered word
- R_READY  input  1  R destination consumes R_OUT this cycle
- STALL_CNT  output  CNT_WIDTH  count of stalled input cycles, saturating

## Operation
- Each destination slot (B, R) runs an independent 2-state FSM: EMPTY or FULL. The slot's VALID output equals (state == FULL).
- Accept: IN_VALID & IN_READY. On the next rising edge, D is written into the slot chosen by DEMUX_SEL, and that slot goes to FULL.
- Drain: slot FULL & slot READY. On the next rising edge, the slot goes to EMPTY unless it is loaded in the same cycle.
- Combinational ready: IN_READY = sel_empty | sel_drain, where sel_* refers to the slot chosen by DEMUX_SEL. This is a combinational path from B_READY/R_READY to IN_READY.
- IN_READY is defined regardless of IN_VALID.
- Simultaneous drain and load of the same slot: the slot stays FULL and holds the new D. The old word counts as delivered.
- Load of one slot with drain of the other in the same cycle: both actions proceed independently.
- Sequential words to the same slot with READY held high sustain one word per cycle.
- Data hold:
  - B_OUT and R_OUT change only on a load.
  - When a slot is EMPTY, its OUT keeps the last loaded value. Consumers must qualify OUT with VALID.
- Stall counter:
  - STALL_CNT increments by 1 on every cycle where IN_VALID & ~IN_READY.
  - It saturates at 2^CNT_WIDTH − 1 and never wraps.
  - It is cleared only by RST.
- DEMUX_SEL and D are ignored when IN_VALID = 0.

## Timing
- Reset values, applied on a clock edge with RST = 1: both slots EMPTY, B_VALID = 0, R_VALID = 0, B_OUT = 0, R_OUT = 0, STALL_CNT = 0. After reset, IN_READY = 1.
- RST has priority over all other inputs. Reset in mid-operation discards any held words, and discarded words are not delivered.
- Latency: a word accepted at edge n appears with VALID = 1 at edge n+1 (1 cycle).
- Throughput: 1 word per cycle per slot when that slot's READY is continuously high.
- Once asserted, VALID stays high and OUT stays stable until the word is drained (standard valid/ready rule).

## Test plan
- Reset, then idle: after one RST cycle, both VALIDs = 0, both OUTs = 0, IN_READY = 1, STALL_CNT = 0.
- Route to B: D = 4'hA, DEMUX_SEL = 1, IN_VALID = 1 for one cycle, B_READY = 0 → next cycle B_VALID = 1, B_OUT = 4'hA, R_VALID = 0. Then assert B_READY → B_VALID = 0 one cycle later, and B_OUT stays 4'hA.
- Backpressure and stall count:
  - Load R with 4'h3 while R_READY = 0.
  - Then hold IN_VALID = 1, DEMUX_SEL = 0, D = 4'h5 for 3 cycles → IN_READY = 0 and STALL_CNT = 3.
  - Raise R_READY → in that cycle IN_READY = 1; next cycle R_OUT = 4'h5, R_VALID = 1.
- Streaming with concurrent traffic:
  - Stream 4'h1, 4'h2, 4'h3 to R on consecutive cycles with R_READY = 1 → R_OUT shows 1, 2, 3 on consecutive cycles, with no stall.
  - At the same time, a held B word is unaffected.
- Reset mid-operation: with both slots FULL (B = 4'hC, R = 4'h7), assert RST for one cycle → both VALIDs = 0, both OUTs = 0, and neither word is delivered.
- Counter saturation: with CNT_WIDTH = 2, stall for 6 cycles → STALL_CNT = 3 and holds at 3.
